// File: rtl/layer_stream_checker.sv
// layer_stream_checker: receive-side endpoint for a layer output stream.
// Every accepted word is compared with a preloaded expected-value memory; the
// block counts mismatches (saturating) and remembers the first failing index.
// s_ready is throttled by a 16-bit Galois LFSR so hardware bring-up sees the
// same stall patterns as simulation.
module layer_stream_checker #(
  parameter int          T         = 8,
  parameter int          NUMVALS   = 16,
  parameter bit          STALL_EN  = 1'b1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         IW        = (NUMVALS > 1) ? $clog2(NUMVALS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  input  logic signed [T-1:0]  s_data,
  output logic                 s_ready,
  input  logic                 exp_we,
  input  logic [IW-1:0]        exp_addr,
  input  logic [T-1:0]         exp_wdata,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          err_count,
  output logic                 first_err_valid,
  output logic [IW-1:0]        first_err_idx
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [15:0] LFSR_MASK = 16'hB400;  // x^16+x^14+x^13+x^11+1
  localparam logic [15:0] ERR_MAX   = 16'hFFFF;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_next;
  logic [T-1:0]  exp_mem [NUMVALS];
  logic          xfer;
  logic          mismatch;
  logic          last_word;

  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
  assign s_ready   = (state == S_RUN) && (lfsr[0] || !STALL_EN);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign xfer      = s_valid && s_ready;
  assign mismatch  = (s_data != exp_mem[idx]);
  assign last_word = (idx == IW'(NUMVALS - 1));

  // Expected-memory write port; open only while no run is in progress.
  // NOTE: the memory has no reset branch so it maps onto RAM and its contents
  // survive a reset, letting a run be repeated without reloading.
  always_ff @(posedge clk) begin
    if (exp_we && (state != S_RUN)) begin
      exp_mem[exp_addr] <= exp_wdata;
    end
  end

  // Run control, LFSR stepping and result accumulation.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= S_IDLE;
      idx             <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      lfsr            <= LFSR_SEED;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state           <= S_RUN;
            idx             <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            lfsr            <= LFSR_SEED;
          end
        end
        S_RUN: begin
          lfsr <= lfsr_next;
          if (xfer) begin
            idx <= idx + 1'b1;
            if (mismatch) begin
              if (err_count != ERR_MAX) begin
                err_count <= err_count + 16'd1;
              end
              if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_idx   <= idx;
              end
            end
            if (last_word) begin
              state <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
